// File: rtl/hidden_cpu_sequencer.sv
// hidden_cpu_sequencer: program buffer and instruction streamer for the
// 8-bit hidden CPU core.
//
// A program is loaded byte by byte over load_valid/load_data/load_ready.
// On start, the CPU is held in reset (cpu_rst) for RST_CYCLES cycles.
// The stored program is then streamed on instr/instr_valid, one byte per cycle.
// A one-cycle done pulse marks normal completion. halt aborts a run.
// busy is high whenever the block is not idle. len is the stored program length.
//
// Ports: clk, rst_n (sync, active-low), load_valid, load_data[7:0], load_ready,
//        clear, start, repeats[3:0], halt, cpu_rst, instr[7:0], instr_valid,
//        busy, done, len[$clog2(DEPTH):0]
//
// Optional feature macro: HIDDEN_SEQ_LOOP_EN. When it is defined, repeats
// adds extra passes over the program. When it is undefined, every run is a
// single pass and the pass counter is not built.
module hidden_cpu_sequencer #(
  parameter int         DEPTH      = 16,
  parameter int         RST_CYCLES = 2,
  parameter logic [7:0] IDLE_INSTR = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  input  logic [7:0]             load_data,
  output logic                   load_ready,
  input  logic                   clear,
  input  logic                   start,
  input  logic [3:0]             repeats,
  input  logic                   halt,
  output logic                   cpu_rst,
  output logic [7:0]             instr,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] len
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CRST, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   idx, idx_d;
  logic [LW-1:0]   len_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            cpu_rst_d, valid_d, done_d, busy_d;
  logic [7:0]      instr_d;
  logic            start_go, accept, more;

`ifdef HIDDEN_SEQ_LOOP_EN
  logic [3:0] pass, pass_d;
  assign more = (pass != 4'd0);
`else
  logic unused_repeats;
  assign unused_repeats = ^repeats;
  assign more = 1'b0;
`endif

  assign load_ready = (state == IDLE) && (len < LW'(DEPTH));
  // clear beats start, and an accepted start beats a same-cycle load
  assign start_go   = start && !clear && (len != '0);
  assign accept     = load_valid && load_ready && !clear && !start_go;

  // Store is not reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && accept) mem[len[AW-1:0]] <= load_data;
  end

  // Outputs are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    len_d     = len;
    cnt_d     = cnt;
    cpu_rst_d = cpu_rst;
    instr_d   = IDLE_INSTR;
    valid_d   = 1'b0;
    done_d    = 1'b0;
`ifdef HIDDEN_SEQ_LOOP_EN
    pass_d    = pass;
`endif
    case (state)
      IDLE: begin
        if (clear) begin
          len_d = '0;
        end else if (start_go) begin
          state_d   = CRST;
          cnt_d     = '0;
          idx_d     = '0;
          cpu_rst_d = 1'b1;
`ifdef HIDDEN_SEQ_LOOP_EN
          pass_d    = repeats;
`endif
        end else if (accept) begin
          len_d = len + LW'(1);
        end
      end
      CRST: begin
        if (halt) begin
          state_d   = IDLE;
          cpu_rst_d = 1'b1;
        end else if (cnt == CW'(RST_CYCLES - 1)) begin
          state_d   = RUN;
          cpu_rst_d = 1'b0;
          valid_d   = 1'b1;
          instr_d   = mem[0];
          idx_d     = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RUN: begin
        if (halt) begin
          state_d   = IDLE;
          cpu_rst_d = 1'b1;
        end else if (LW'(idx) == len - LW'(1)) begin
          // end of a pass: wrap with no bubble, or finish
          if (more) begin
            idx_d   = '0;
            valid_d = 1'b1;
            instr_d = mem[0];
`ifdef HIDDEN_SEQ_LOOP_EN
            pass_d  = pass - 4'd1;
`endif
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d   = idx + AW'(1);
          valid_d = 1'b1;
          instr_d = mem[idx_d];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= '0;
      cnt         <= '0;
      cpu_rst     <= 1'b1;
      instr       <= IDLE_INSTR;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
`ifdef HIDDEN_SEQ_LOOP_EN
      pass        <= 4'd0;
`endif
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      len         <= len_d;
      cnt         <= cnt_d;
      cpu_rst     <= cpu_rst_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      done        <= done_d;
      busy        <= busy_d;
`ifdef HIDDEN_SEQ_LOOP_EN
      pass        <= pass_d;
`endif
    end
  end
endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// Self-checking bench for hidden_cpu_sequencer (default parameters).
// The reference model is a byte queue plus the run rule: RST_CYCLES reset
// cycles, len*(passes+1) instructions, one done cycle, then idle.
module tb_hidden_cpu_sequencer;
  localparam int DEPTH = 16;
  localparam int RST   = 2;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       load_valid = 1'b0, clear = 1'b0, start = 1'b0, halt = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [3:0] repeats = 4'd0;
  logic       load_ready, cpu_rst, instr_valid, busy, done;
  logic [7:0] instr;
  logic [4:0] len;

  int errors = 0;
  int checks = 0;
  logic [7:0] prog[$];

  hidden_cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .clear(clear), .start(start), .repeats(repeats),
    .halt(halt), .cpu_rst(cpu_rst), .instr(instr), .instr_valid(instr_valid),
    .busy(busy), .done(done), .len(len)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_rst);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".instr"}, 32'(instr), 32'h00);
    chk({tag, ".done"},  32'(done), 32'd0);
    chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(exp_rst));
  endtask

  // leaves load_valid high so back-to-back calls stream one byte per cycle
  task automatic load_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    chk("load_ready", 32'(load_ready), 32'(prog.size() < DEPTH));
    tick();
    if (prog.size() < DEPTH) prog.push_back(b);
    chk("len_after_load", 32'(len), 32'(prog.size()));
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog.delete();
    chk("len_after_clear", 32'(len), 32'd0);
  endtask

  task automatic crst_phase;
    for (int k = 0; k < RST; k++) begin
      chk("crst.busy", 32'(busy), 32'd1);
      chk("crst.cpu_rst", 32'(cpu_rst), 32'd1);
      chk("crst.valid", 32'(instr_valid), 32'd0);
      tick();
    end
  endtask

  task automatic run(input int rep);
    int passes, n;
`ifdef HIDDEN_SEQ_LOOP_EN
    passes = rep;
`else
    passes = 0;
`endif
    n = prog.size() * (passes + 1);
    repeats = 4'(rep);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeats = 4'd0;
    crst_phase();
    for (int i = 0; i < n; i++) begin
      chk("run.valid", 32'(instr_valid), 32'd1);
      chk("run.instr", 32'(instr), 32'(prog[i % prog.size()]));
      chk("run.cpu_rst", 32'(cpu_rst), 32'd0);
      tick();
    end
    chk("done.pulse", 32'(done), 32'd1);
    chk("done.valid", 32'(instr_valid), 32'd0);
    chk("done.busy", 32'(busy), 32'd1);
    tick();
    chk_idle("after_run", 1'b0);
    chk("after_run.len", 32'(len), 32'(prog.size()));
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk_idle("reset", 1'b1);
    chk("reset.len", 32'(len), 32'd0);
    chk("reset.load_ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // start with an empty store is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_idle("empty_start", 1'b1);
    tick();
    chk("empty_start.busy2", 32'(busy), 32'd0);

    // directed program, single pass then repeats=2
    load_byte(8'hA5);
    load_byte(8'h3C);
    load_byte(8'hF0);
    load_valid = 1'b0;
    run(0);
    run(2);

    // clear wins over a same-cycle load
    load_valid = 1'b1;
    load_data  = 8'h77;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load_valid = 1'b0;
    prog.delete();
    chk("clear_vs_load.len", 32'(len), 32'd0);

    // random programs and pass counts
    for (int it = 0; it < 4; it++) begin
      int n;
      do_clear();
      n = int'($urandom_range(1, 8));
      for (int j = 0; j < n; j++) load_byte(8'($urandom));
      load_valid = 1'b0;
      run(int'($urandom_range(0, 3)));
    end

    // overfill: 20 bytes offered back to back, only DEPTH accepted
    do_clear();
    for (int j = 0; j < 20; j++) load_byte(8'($urandom));
    load_valid = 1'b0;
    chk("full.len", 32'(len), 32'(DEPTH));
    chk("full.load_ready", 32'(load_ready), 32'd0);
    run(0);

    // halt on the 2nd RUN cycle, then replay from mem[0]
    do_clear();
    load_byte(8'h11);
    load_byte(8'h22);
    load_byte(8'h33);
    load_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    crst_phase();
    chk("halt.first", 32'(instr), 32'(prog[0]));
    tick();
    chk("halt.second", 32'(instr), 32'(prog[1]));
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk_idle("halted", 1'b1);
    chk("halted.len", 32'(len), 32'd3);
    run(0);

    // reset asserted mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    crst_phase();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    prog.delete();
    chk_idle("midrun_reset", 1'b1);
    chk("midrun_reset.len", 32'(len), 32'd0);
    chk("midrun_reset.load_ready", 32'(load_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hidden_cpu_sequencer.md
# hidden_cpu_sequencer

Instruction sequencer for the 8-bit hidden CPU core. The CPU takes one instruction per clock on its instruction byte and has no program storage of its own. This block buffers a program loaded over a valid/ready byte port and holds the CPU in reset for a fixed window. It then streams the stored program into the CPU one instruction per cycle, optionally repeating it, and reports completion.

## Interface
Parameters:
- DEPTH, 16, program store entries (power of two, 2..256)
- RST_CYCLES, 2, cycles `cpu_rst` is held before streaming (≥1)
- IDLE_INSTR, 8'h00, byte driven on `instr` whenever `instr_valid` is low

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- load_valid  in  1  load byte present
- load_data  in  8  program byte
- load_ready  out  1  store accepts a byte this cycle
- clear  in  1  discard stored program (IDLE only)
- start  in  1  begin execution (IDLE only)
- repeats  in  4  extra passes after the first, sampled on accepted `start`
- halt  in  1  abort execution
- cpu_rst  out  1  reset to the CPU core
- instr  out  8  instruction byte to the CPU
- instr_valid  out  1  `instr` is a program instruction
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on normal completion
- len  out  log2(DEPTH)+1  number of stored instructions

## Operation
- States: IDLE, CRST, RUN, DONE.
- Reset values (`rst_n`=0): state IDLE, `len`=0, write ptr 0, `cpu_rst`=1, `instr`=IDLE_INSTR, `instr_valid`=0, `done`=0, `busy`=0. Store contents are not reset.
- Loading:
  - `load_ready` = (state==IDLE) && (`len` < DEPTH).
  - A byte is accepted when `load_valid` && `load_ready`. It is written to mem[`len`] and `len` increments.
  - A byte offered while full or not in IDLE is not accepted and has no effect.
- `clear` in IDLE sets `len`=0 and takes priority over a same-cycle load. `clear` in other states is ignored.
- `start` in IDLE:
  - If `len`==0, it is ignored and the state stays IDLE.
  - Otherwise the block latches pass count = `repeats`, sets rd idx=0 and goes to CRST.
  - `start` takes priority over a same-cycle load; that load is not accepted.
- CRST: `cpu_rst`=1 for exactly RST_CYCLES cycles, then RUN.
- RUN:
  - Each cycle, `instr`=mem[idx] and `instr_valid`=1.
  - At idx==`len`-1, idx wraps to 0. If pass count > 0, it decrements and RUN continues; otherwise the state goes to DONE.
- DONE: `done`=1 for one cycle, `instr_valid`=0, then IDLE.
- `cpu_rst`:
  - Stays 1 in IDLE until the first RUN.
  - Is 0 during RUN and DONE.
  - Returns to 0 in IDLE after a completed run, so the CPU holds its state for inspection.
- `halt` in CRST or RUN: the next cycle is IDLE with `instr_valid`=0, `instr`=IDLE_INSTR, `cpu_rst`=1 and no `done`. `halt` in IDLE or DONE is ignored.
- `len` and store contents survive a run and a halt, so `start` replays the same program.

## Timing
- All outputs are registered.
- `start` sampled at edge T: `busy`/`cpu_rst`=1 from T+1. The first RUN cycle (mem[0] valid) is T+1+RST_CYCLES.
- Instruction count per run = `len`×(`repeats`+1), back-to-back with no bubble at pass wrap.
- `done` is asserted in the cycle after the last `instr_valid` cycle. `busy` falls in the cycle after `done`.
- Load throughput: 1 byte/cycle. `load_ready` deasserts in the cycle after the DEPTH-th accept.
- `rst_n` low mid-run: the next cycle is the reset state, with no `done` and `len`=0.

## Configuration
- `HIDDEN_SEQ_LOOP_EN` defined: `repeats` is honoured as above.
- Undefined: `repeats` is ignored and the pass count is forced to 0, giving a single pass. The pass-count register and its decrement logic are not built.

## Test plan
- Load 3 bytes A5,3C,F0, then pulse `start` with `repeats`=0 → `cpu_rst` high for 2 cycles, then `instr` = A5,3C,F0 on three consecutive valid cycles, then `done` for 1 cycle, then `busy`=0 and `len`=3.
- Same program, `repeats`=2 (LOOP_EN defined) → 9 valid cycles cycling A5,3C,F0 with no gap, then `done`. With LOOP_EN undefined → 3 valid cycles only.
- Hold `load_valid` high with 20 bytes, DEPTH=16 → exactly 16 accepted, `len`=16, `load_ready`=0 from the cycle after the 16th accept.
- `start` with `len`=0 → no state change: `busy`=0, `cpu_rst`=1. `clear` and `load_valid` asserted in the same cycle → `len`=0.
- Assert `halt` on the 2nd RUN cycle of a 3-instr program → next cycle `instr_valid`=0, `instr`=00, `cpu_rst`=1, no `done`. A subsequent `start` replays from mem[0].
- Drive `rst_n`=0 for one cycle mid-RUN → reset values on all outputs, `len`=0, `load_ready`=1.
